turn_scheduler: RTL and testbench

//  Connect-4 turn FSM. Alternates the board resource between the human player (P1, switch/button

---
 rtl/turn_scheduler_if.sv | 38 +++
 rtl/turn_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_turn_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_scheduler_if.sv
// Signal bundle between the Connect-4 turn scheduler and its neighbours
// (debouncer, random move generator, board writer, win checker).
// Handshakes: place_req rises with place_col/place_player valid and holds all three
// stable until the single-cycle place_done pulse; rmg_enable is a one-cycle request
// answered by rmg_valid/rmg_col within RMG_WAIT cycles; start/human_valid are pulses.
interface turn_scheduler_if;
  logic       start;
  logic       human_valid;
  logic [2:0] human_col;
  logic [6:0] col_full;
  logic       rmg_enable;
  logic       rmg_valid;
  logic [2:0] rmg_col;
  logic       place_req;
  logic [2:0] place_col;
  logic [1:0] place_player;
  logic       place_done;
  logic       win;
  logic       draw;
  logic [1:0] cur_player;
  logic [3:0] secs_left;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    input  start, human_valid, human_col, col_full, rmg_valid, rmg_col,
           place_done, win, draw,
    output rmg_enable, place_req, place_col, place_player, cur_player,
           secs_left, game_over, winner
  );

  modport slave (
    output start, human_valid, human_col, col_full, rmg_valid, rmg_col,
           place_done, win, draw,
    input  rmg_enable, place_req, place_col, place_player, cur_player,
           secs_left, game_over, winner
  );
endinterface

// File: rtl/turn_scheduler.sv
// Connect-4 turn FSM: alternates P1 (human) and P2 (generator), serialises moves to the board.
// Optional human turn timeout selected by defining TURN_TIMEOUT_EN.
module turn_scheduler #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 10,
    parameter int RMG_WAIT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    turn_scheduler_if.master       bus,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_WAIT  = 3'd1,
        CPU_REQ  = 3'd2,
        CPU_WAIT = 3'd3,
        PLACE    = 3'd4,
        CHECK    = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam int WAIT_W = (RMG_WAIT > 1) ? $clog2(RMG_WAIT) : 1;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;
    localparam logic [1:0] TIE = 2'b11;

    state_t            state_q, state_d;
    logic [2:0]        place_col_q, place_col_d;
    logic [1:0]        place_player_q, place_player_d;
    logic [1:0]        cur_player_q, cur_player_d;
    logic [1:0]        winner_q, winner_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        full8;
    logic              human_ok;
    logic              rmg_ok;
    logic              p1_auto;

    // Column 7 is folded in as permanently full so one lookup rejects it.
    assign full8    = {1'b1, bus.col_full};
    assign human_ok = bus.human_valid && !full8[bus.human_col];
    assign rmg_ok   = bus.rmg_valid && !full8[bus.rmg_col];

`ifdef TURN_TIMEOUT_EN
    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        secs_q, secs_d;
    logic              timeout_q, timeout_d;

    assign p1_auto = timeout_q;
`else
    logic unused_cfg;

    assign unused_cfg = (CLK_HZ == TURN_SECONDS);
    assign p1_auto    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            place_col_q    <= 3'd0;
            place_player_q <= 2'd0;
            cur_player_q   <= 2'd0;
            winner_q       <= 2'd0;
            wait_q         <= '0;
`ifdef TURN_TIMEOUT_EN
            tick_q         <= '0;
            secs_q         <= 4'd0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            place_col_q    <= place_col_d;
            place_player_q <= place_player_d;
            cur_player_q   <= cur_player_d;
            winner_q       <= winner_d;
            wait_q         <= wait_d;
`ifdef TURN_TIMEOUT_EN
            tick_q         <= tick_d;
            secs_q         <= secs_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        place_col_d    = place_col_q;
        place_player_d = place_player_q;
        cur_player_d   = cur_player_q;
        winner_d       = winner_q;
        wait_d         = wait_q;
`ifdef TURN_TIMEOUT_EN
        tick_d         = tick_q;
        secs_d         = secs_q;
        timeout_d      = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = P1_WAIT;
                    cur_player_d = P1;
                    winner_d     = 2'b00;
`ifdef TURN_TIMEOUT_EN
                    tick_d       = '0;
                    secs_d       = 4'(TURN_SECONDS);
                    timeout_d    = 1'b0;
`endif
                end
            end
            P1_WAIT: begin
                if (human_ok) begin
                    state_d        = PLACE;
                    place_col_d    = bus.human_col;
                    place_player_d = P1;
`ifdef TURN_TIMEOUT_EN
                    secs_d         = 4'd0;
                end else if (secs_q == 4'd0) begin
                    // Expired turn: the generator picks the column on P1's behalf.
                    state_d   = CPU_REQ;
                    timeout_d = 1'b1;
                end else if (tick_q == TICK_W'(CLK_HZ - 1)) begin
                    tick_d = '0;
                    secs_d = secs_q - 4'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
`endif
                end
            end
            CPU_REQ: begin
                state_d = CPU_WAIT;
                wait_d  = '0;
            end
            CPU_WAIT: begin
                if (rmg_ok) begin
                    state_d        = PLACE;
                    place_col_d    = bus.rmg_col;
                    place_player_d = p1_auto ? P1 : P2;
                end else if (wait_q == WAIT_W'(RMG_WAIT - 1)) begin
                    // Generator found no free column: the board is effectively drawn.
                    state_d      = DONE;
                    winner_d     = TIE;
                    cur_player_d = 2'b00;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            PLACE: begin
                if (bus.place_done) state_d = CHECK;
            end
            CHECK: begin
                if (bus.win) begin
                    state_d      = DONE;
                    winner_d     = place_player_q;
                    cur_player_d = 2'b00;
                end else if (bus.draw) begin
                    state_d      = DONE;
                    winner_d     = TIE;
                    cur_player_d = 2'b00;
                end else if (place_player_q == P1) begin
                    state_d      = CPU_REQ;
                    cur_player_d = P2;
`ifdef TURN_TIMEOUT_EN
                    timeout_d    = 1'b0;
`endif
                end else begin
                    state_d      = P1_WAIT;
                    cur_player_d = P1;
`ifdef TURN_TIMEOUT_EN
                    tick_d       = '0;
                    secs_d       = 4'(TURN_SECONDS);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rmg_enable   = (state_q == CPU_REQ);
    assign bus.place_req    = (state_q == PLACE);
    assign bus.place_col    = place_col_q;
    assign bus.place_player = place_player_q;
    assign bus.cur_player   = cur_player_q;
    assign bus.game_over    = (state_q == DONE);
    assign bus.winner       = winner_q;
`ifdef TURN_TIMEOUT_EN
    assign bus.secs_left    = secs_q;
`else
    assign bus.secs_left    = 4'd0;
`endif
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: place requests and game results are checked by a
// monitor against expected queues filled by the stimulus sequence.
module tb_turn_scheduler;
  localparam int CLK_HZ       = 4;
  localparam int TURN_SECONDS = 2;
  localparam int RMG_WAIT     = 8;
`ifdef TURN_TIMEOUT_EN
  localparam logic [3:0] EXP_SECS = 4'(TURN_SECONDS);
`else
  localparam logic [3:0] EXP_SECS = 4'd0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  int         checks;
  int         errors;

  turn_scheduler_if bus ();

  turn_scheduler #(
    .CLK_HZ       (CLK_HZ),
    .TURN_SECONDS (TURN_SECONDS),
    .RMG_WAIT     (RMG_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard queues: {place_col, place_player} and final winner
  logic [4:0] exp_q[$];
  logic [1:0] exp_win_q[$];
  logic [4:0] held_place;
  logic       req_prev, go_prev, rmg_prev;

  initial begin
    req_prev = 1'b0;
    go_prev  = 1'b0;
    rmg_prev = 1'b0;
    held_place = '0;
  end

  always @(negedge clk) begin
    if (bus.place_req && !req_prev) begin
      held_place = {bus.place_col, bus.place_player};
      if (exp_q.size() == 0) check("place_unexpected", {11'd0, held_place}, 16'hffff);
      else check("place_txn", {11'd0, held_place}, {11'd0, exp_q.pop_front()});
    end
    if (bus.place_req && bus.place_done)
      check("place_stable", {11'd0, bus.place_col, bus.place_player}, {11'd0, held_place});
    if (bus.game_over && !go_prev) begin
      if (exp_win_q.size() == 0) check("winner_unexpected", {14'd0, bus.winner}, 16'hffff);
      else check("winner", {14'd0, bus.winner}, {14'd0, exp_win_q.pop_front()});
    end
    if (rmg_prev) check("rmg_one_cycle", {15'd0, bus.rmg_enable}, 16'd0);
    req_prev = bus.place_req;
    go_prev  = bus.game_over;
    rmg_prev = bus.rmg_enable;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic human_move(input logic [2:0] col);
    bus.human_valid = 1'b1;
    bus.human_col   = col;
    step(1);
    bus.human_valid = 1'b0;
  endtask

  task automatic serve_place(input logic w, input logic d);
    int n = 0;
    while (!bus.place_req && n < 20) begin
      step(1);
      n++;
    end
    check("place_req_seen", {15'd0, bus.place_req}, 16'd1);
    step(1);
    bus.place_done = 1'b1;
    bus.win        = w;
    bus.draw       = d;
    step(1);
    bus.place_done = 1'b0;
    step(1);
    bus.win  = 1'b0;
    bus.draw = 1'b0;
  endtask

  task automatic serve_rmg(input logic give, input logic [2:0] col);
    int n = 0;
    while (!bus.rmg_enable && n < 20) begin
      step(1);
      n++;
    end
    check("rmg_enable_seen", {15'd0, bus.rmg_enable}, 16'd1);
    step(1);
    if (give) begin
      bus.rmg_valid = 1'b1;
      bus.rmg_col   = col;
      step(1);
      bus.rmg_valid = 1'b0;
    end
  endtask

  function automatic logic [15:0] all_outputs();
    return {bus.place_req, bus.rmg_enable, bus.game_over, bus.cur_player, bus.winner,
            bus.secs_left, bus.place_col, bus.place_player};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.human_valid = 1'b0;
    bus.human_col = 3'd0;
    bus.col_full = 7'd0;
    bus.rmg_valid = 1'b0;
    bus.rmg_col = 3'd0;
    bus.place_done = 1'b0;
    bus.win = 1'b0;
    bus.draw = 1'b0;
    step(2);
    check("reset_outputs", all_outputs(), 16'd0);
    check("reset_state", {13'd0, state_dbg}, 16'd0);
    rst = 1'b1;
    step(1);

    // human col 3, then CPU col 5
    pulse_start();
    check("start_cur_player", {14'd0, bus.cur_player}, 16'h1);
    check("start_secs_left", {12'd0, bus.secs_left}, {12'd0, EXP_SECS});
    exp_q.push_back({3'd3, 2'b01});
    human_move(3'd3);
    pulse_start();
    check("start_ignored_in_place", {13'd0, state_dbg}, 16'd4);
    serve_place(1'b0, 1'b0);
    exp_q.push_back({3'd5, 2'b10});
    serve_rmg(1'b1, 3'd5);
    serve_place(1'b0, 1'b0);
    check("back_to_p1", {14'd0, bus.cur_player}, 16'h1);

    // invalid columns ignored
    bus.col_full = 7'b0001000;
    human_move(3'd3);
    check("full_col_ignored", {12'd0, bus.place_req, state_dbg}, 16'd1);
    human_move(3'd7);
    check("col7_ignored", {12'd0, bus.place_req, state_dbg}, 16'd1);
    exp_q.push_back({3'd2, 2'b01});
    human_move(3'd2);
    serve_place(1'b0, 1'b0);

    // win and draw together after a P2 move: win has priority
    exp_q.push_back({3'd4, 2'b10});
    serve_rmg(1'b1, 3'd4);
    exp_win_q.push_back(2'b10);
    serve_place(1'b1, 1'b1);
    check("done_flags", {13'd0, bus.game_over, bus.cur_player}, 16'h4);
    pulse_start();
    check("restart_clears", {11'd0, bus.game_over, bus.winner, bus.cur_player}, 16'h1);

    // generator silent for RMG_WAIT cycles
    bus.col_full = 7'd0;
    exp_q.push_back({3'd0, 2'b01});
    human_move(3'd0);
    serve_place(1'b0, 1'b0);
    exp_win_q.push_back(2'b11);
    serve_rmg(1'b0, 3'd0);
    step(RMG_WAIT - 1);
    check("rmg_wait_not_done", {15'd0, bus.game_over}, 16'd0);
    step(1);
    check("rmg_timeout_done", {13'd0, bus.game_over, bus.cur_player}, 16'h4);

    // P1 wins directly
    pulse_start();
    exp_q.push_back({3'd1, 2'b01});
    exp_win_q.push_back(2'b01);
    human_move(3'd1);
    serve_place(1'b1, 1'b0);

    // draw after a P2 move
    pulse_start();
    exp_q.push_back({3'd2, 2'b01});
    human_move(3'd2);
    serve_place(1'b0, 1'b0);
    exp_q.push_back({3'd3, 2'b10});
    serve_rmg(1'b1, 3'd3);
    exp_win_q.push_back(2'b11);
    serve_place(1'b0, 1'b1);

    // async reset while place_req is high
    pulse_start();
    exp_q.push_back({3'd6, 2'b01});
    human_move(3'd6);
    step(1);
    check("req_before_reset", {15'd0, bus.place_req}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 16'd0);
    check("async_reset_state", {13'd0, state_dbg}, 16'd0);
    step(1);
    rst = 1'b1;
    step(1);
    pulse_start();
    check("after_reset_start", {14'd0, bus.cur_player}, 16'h1);

`ifdef TURN_TIMEOUT_EN
    check("timer_secs_2", {12'd0, bus.secs_left}, 16'd2);
    step(CLK_HZ - 1);
    check("timer_secs_2_hold", {12'd0, bus.secs_left}, 16'd2);
    step(1);
    check("timer_secs_1", {12'd0, bus.secs_left}, 16'd1);
    step(CLK_HZ);
    check("timer_secs_0", {12'd0, bus.secs_left}, 16'd0);
    exp_q.push_back({3'd1, 2'b01});
    serve_rmg(1'b1, 3'd1);
    serve_place(1'b0, 1'b0);
    check("after_timeout_cpu_turn", {14'd0, bus.cur_player}, 16'h2);
`else
    step(20);
    check("no_timer_secs", {12'd0, bus.secs_left}, 16'd0);
    check("p1_waits", {13'd0, state_dbg}, 16'd1);
`endif

    step(2);
    check("place_queue_drained", 16'(exp_q.size()), 16'd0);
    check("winner_queue_drained", 16'(exp_win_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
